// File: rtl/button_conditioner.sv
// Five-button conditioner: synchronise, debounce, level report and one-cycle press pulses.
// Define BTN_AUTOREPEAT_EN to add hold-to-repeat pulses on btnU and btnD.
module button_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES     = 1000000,
  parameter int unsigned REPEAT_DELAY_CYCLES = 50000000,
  parameter int unsigned REPEAT_RATE_CYCLES  = 10000000
) (
  input  logic       clock_100mhz,
  input  logic       reset_n,
  input  logic       btnU,
  input  logic       btnD,
  input  logic       btnL,
  input  logic       btnR,
  input  logic       btnC,
  input  logic       menu_active,
  output logic       btnU_pulse,
  output logic       btnD_pulse,
  output logic       btnL_pulse,
  output logic       btnR_pulse,
  output logic       btnC_pulse,
  output logic [4:0] btn_level
);

  localparam int unsigned NUM_BTNS = 5;
  localparam int unsigned CNT_W    = 24;
  localparam int unsigned CNT_MAX  = (32'd1 << CNT_W) - 32'd1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 32'd1);

  // Elaboration-time parameter sanity
  if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > CNT_MAX) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES out of range 2..2^24-1");
  end
  if (REPEAT_DELAY_CYCLES < 1 || REPEAT_RATE_CYCLES < 1) begin : g_bad_repeat
    $error("REPEAT_DELAY_CYCLES and REPEAT_RATE_CYCLES must be at least 1");
  end

  logic [NUM_BTNS-1:0] raw_c;
  logic [NUM_BTNS-1:0] sync_meta;
  logic [NUM_BTNS-1:0] sync_q;
  logic [NUM_BTNS-1:0] stable_q;
  logic [NUM_BTNS-1:0] stable_d_c;
  logic [NUM_BTNS-1:0] rise_q;
  logic [NUM_BTNS-1:0] pulse_q;
  logic [NUM_BTNS-1:0] rep_fire_c;
  logic [CNT_W-1:0]    cnt_q   [NUM_BTNS];
  logic [CNT_W-1:0]    cnt_d_c [NUM_BTNS];

  assign raw_c = {btnC, btnR, btnL, btnD, btnU};

  // Two-flop synchroniser on every raw button
  always_ff @(posedge clock_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= raw_c;
      sync_q    <= sync_meta;
    end
  end

  // Debounce: count consecutive disagreeing samples, flip after DEBOUNCE_CYCLES of them
  always_comb begin
    stable_d_c = stable_q;
    for (int i = 0; i < NUM_BTNS; i++) begin
      cnt_d_c[i] = '0;
      if (sync_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d_c[i] = ~stable_q[i];
        end else begin
          cnt_d_c[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clock_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= '0;
      for (int i = 0; i < NUM_BTNS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      stable_q <= stable_d_c;
      for (int i = 0; i < NUM_BTNS; i++) begin
        cnt_q[i] <= cnt_d_c[i];
      end
    end
  end

`ifdef BTN_AUTOREPEAT_EN
  localparam int unsigned TMR_W    = 32;
  localparam int unsigned REP_BTNS = 2;

  logic [TMR_W-1:0]    rep_tmr_q [REP_BTNS];
  logic [REP_BTNS-1:0] rep_on_q;

  // Repeat fires on timer expiry while the debounced level is still held
  always_comb begin
    rep_fire_c = '0;
    for (int i = 0; i < REP_BTNS; i++) begin
      rep_fire_c[i] = rep_on_q[i] & stable_d_c[i] & ~rise_q[i] & (rep_tmr_q[i] == '0);
    end
  end

  // Timer armed by the press, reloaded at the repeat rate, dropped on release
  always_ff @(posedge clock_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      rep_on_q <= '0;
      for (int i = 0; i < REP_BTNS; i++) begin
        rep_tmr_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REP_BTNS; i++) begin
        if (!stable_d_c[i]) begin
          rep_on_q[i]  <= 1'b0;
          rep_tmr_q[i] <= '0;
        end else if (rise_q[i]) begin
          rep_on_q[i]  <= 1'b1;
          rep_tmr_q[i] <= TMR_W'(REPEAT_DELAY_CYCLES - 32'd1);
        end else if (rep_on_q[i]) begin
          if (rep_tmr_q[i] == '0) begin
            rep_tmr_q[i] <= TMR_W'(REPEAT_RATE_CYCLES - 32'd1);
          end else begin
            rep_tmr_q[i] <= rep_tmr_q[i] - TMR_W'(1);
          end
        end
      end
    end
  end
`else
  assign rep_fire_c = '0;
`endif

  // Level report, rising-edge detect and gated pulse stage
  always_ff @(posedge clock_100mhz or negedge reset_n) begin
    if (!reset_n) begin
      btn_level <= '0;
      rise_q    <= '0;
      pulse_q   <= '0;
    end else begin
      btn_level <= stable_q;
      rise_q    <= stable_q & ~btn_level;
      pulse_q   <= (rise_q | rep_fire_c) & {NUM_BTNS{menu_active}};
    end
  end

  assign btnU_pulse = pulse_q[0];
  assign btnD_pulse = pulse_q[1];
  assign btnL_pulse = pulse_q[2];
  assign btnR_pulse = pulse_q[3];
  assign btnC_pulse = pulse_q[4];

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: per-cycle check against a sample-window model plus directed latency checks.
module tb_button_conditioner;

  localparam int D      = 4;
  localparam int RDELAY = 20;
  localparam int RRATE  = 8;

  logic       clock_100mhz = 1'b0;
  logic       reset_n      = 1'b0;
  logic       btn_u = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_r = 1'b0, btn_c = 1'b0;
  logic       menu_active = 1'b1;
  logic       pu, pd, pl, pr, pc;
  logic [4:0] btn_level;
  logic [4:0] pulse_vec;

  button_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_DELAY_CYCLES(RDELAY),
    .REPEAT_RATE_CYCLES(RRATE)
  ) dut (
    .clock_100mhz(clock_100mhz),
    .reset_n(reset_n),
    .btnU(btn_u),
    .btnD(btn_d),
    .btnL(btn_l),
    .btnR(btn_r),
    .btnC(btn_c),
    .menu_active(menu_active),
    .btnU_pulse(pu),
    .btnD_pulse(pd),
    .btnL_pulse(pl),
    .btnR_pulse(pr),
    .btnC_pulse(pc),
    .btn_level(btn_level)
  );

  assign pulse_vec = {pc, pr, pl, pd, pu};

  initial forever #5 clock_100mhz = ~clock_100mhz;

  int n_cmp  = 0;
  int n_fail = 0;
  int tcyc   = 0;
  bit cmp_en = 1'b0;

  initial forever begin
    @(posedge clock_100mhz);
    tcyc++;
  end

  // Model: raw seen two edges late; level accepted after D consecutive disagreeing samples
  logic [4:0]   d1 = '0, d2 = '0, st = '0;
  logic [D-1:0] win [5];
  int           rise_at [5];
  int           mcyc = 0;
  logic [4:0]   exp_pulse = '0, exp_level = '0;

  initial begin
    for (int i = 0; i < 5; i++) begin
      win[i] = '0;
      rise_at[i] = -1;
    end
    forever begin
      @(posedge clock_100mhz or negedge reset_n);
      if (!reset_n) begin
        d1 = '0; d2 = '0; st = '0; mcyc = 0;
        exp_pulse = '0; exp_level = '0;
        for (int i = 0; i < 5; i++) begin
          win[i] = '0;
          rise_at[i] = -1;
        end
      end else begin
        for (int i = 0; i < 5; i++) begin
          logic [4:0]   raw;
          logic [D-1:0] w;
          bit           flip, fire;
          int           p;
          raw  = {btn_c, btn_r, btn_l, btn_d, btn_u};
          w    = {win[i][D-2:0], d2[i]};
          flip = (w == {D{~st[i]}});
          fire = (rise_at[i] >= 0) && (mcyc == rise_at[i] + 2);
          p    = rise_at[i] + 2;
`ifdef BTN_AUTOREPEAT_EN
          if (i < 2 && st[i] && !flip && rise_at[i] >= 0 && mcyc >= p + RDELAY &&
              ((mcyc - p - RDELAY) % RRATE) == 0)
            fire = 1'b1;
`endif
          exp_pulse[i] = fire && menu_active;
          exp_level[i] = st[i];
          if (flip) begin
            rise_at[i] = st[i] ? -1 : mcyc;
            st[i] = ~st[i];
          end
          win[i] = w;
          d2[i]  = d1[i];
          d1[i]  = raw[i];
        end
        mcyc++;
      end
    end
  end

  // Per-cycle compare and pulse/level monitors
  int   pcnt [5];
  int   last_pulse [5];
  int   first_level [5];
  logic [4:0] lvl_ever = '0;
  int   u_edges [$];

  initial forever begin
    @(negedge clock_100mhz);
    if (cmp_en) begin
      n_cmp++;
      if (pulse_vec !== exp_pulse || btn_level !== exp_level) begin
        n_fail++;
        $display("FAIL cycle_model edge=%0d pulses=%b required=%b level=%b required=%b",
                 tcyc, pulse_vec, exp_pulse, btn_level, exp_level);
      end
    end
    if (reset_n) begin
      for (int i = 0; i < 5; i++) begin
        if (pulse_vec[i]) begin
          pcnt[i]++;
          last_pulse[i] = tcyc;
          if (i == 0) u_edges.push_back(tcyc);
        end
        if (btn_level[i] && first_level[i] < 0) first_level[i] = tcyc;
      end
      lvl_ever |= btn_level;
    end
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock_100mhz);
    #2;
  endtask

  task automatic clear_mon();
    for (int i = 0; i < 5; i++) begin
      pcnt[i] = 0;
      last_pulse[i] = -1;
      first_level[i] = -1;
    end
    lvl_ever = '0;
    u_edges.delete();
  endtask

  initial begin
    int t0;
    int offs [6];
    offs = '{0, 20, 28, 36, 44, 52};
    clear_mon();

    // Reset
    step(2);
    cmp_en = 1'b1;
    step(1);
    check("reset_level", 32'(btn_level), 0);
    check("reset_pulses", 32'(pulse_vec), 0);
    reset_n = 1'b1;
    step(2);

    // Clean press and release of btnU
    clear_mon();
    t0 = tcyc;
    btn_u = 1'b1;
    step(12);
    check("press_count_u", pcnt[0], 1);
    check("press_latency_u", last_pulse[0] - (t0 + 1), 7);
    check("level_latency_u", first_level[0] - (t0 + 1), 6);
    check("level_held_u", 32'(btn_level), 1);
    btn_u = 1'b0;
    step(10);
    check("release_no_pulse_u", pcnt[0], 1);
    check("level_released_u", 32'(btn_level), 0);

    // Glitch on btnD
    clear_mon();
    btn_d = 1'b1;
    step(3);
    btn_d = 1'b0;
    step(10);
    check("glitch_pulses_d", pcnt[1], 0);
    check("glitch_level", 32'(lvl_ever), 0);

    // Simultaneous btnU + btnD
    clear_mon();
    t0 = tcyc;
    btn_u = 1'b1;
    btn_d = 1'b1;
    step(12);
    check("simul_count_u", pcnt[0], 1);
    check("simul_count_d", pcnt[1], 1);
    check("simul_same_edge", last_pulse[1], last_pulse[0]);
    check("simul_latency", last_pulse[0] - (t0 + 1), 7);
    btn_u = 1'b0;
    btn_d = 1'b0;
    step(10);

    // Gated btnC press, menu raised while still held
    clear_mon();
    menu_active = 1'b0;
    btn_c = 1'b1;
    step(10);
    menu_active = 1'b1;
    step(5);
    check("gated_count_c", pcnt[4], 0);
    check("gated_level_c", 32'(btn_level[4]), 1);
    btn_c = 1'b0;
    step(10);

    // Reset two cycles into btnL debounce, button kept high
    clear_mon();
    btn_l = 1'b1;
    step(2);
    reset_n = 1'b0;
    step(1);
    check("midreset_level", 32'(btn_level), 0);
    check("midreset_pulses", 32'(pulse_vec), 0);
    step(1);
    reset_n = 1'b1;
    t0 = tcyc;
    step(12);
    check("postreset_count_l", pcnt[2], 1);
    check("postreset_latency_l", last_pulse[2] - (t0 + 1), 7);
    btn_l = 1'b0;
    step(10);

    // Long hold of btnU
    clear_mon();
    t0 = tcyc;
    btn_u = 1'b1;
    step(60);
    btn_u = 1'b0;
    step(20);
    check("hold_first_latency", (u_edges.size() > 0) ? u_edges[0] - (t0 + 1) : -1, 7);
`ifdef BTN_AUTOREPEAT_EN
    check("repeat_count", u_edges.size(), 6);
    for (int k = 1; k < 6; k++) begin
      check($sformatf("repeat_offset_%0d", k),
            (k < u_edges.size()) ? u_edges[k] - (t0 + 8) : -1, offs[k]);
    end
`else
    check("hold_single_pulse", u_edges.size(), 1);
    check("hold_first_offset", (u_edges.size() > 0) ? u_edges[0] - (t0 + 8) : -1, offs[0]);
`endif

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
